press_classifier: RTL and testbench
===================================

Name: press_classifier

Overview:
- Sits downstream of debounce and consumes its clean, synchronous level output.
- Classifies each button gesture as a short press, a double press or a long press, and emits one single-cycle pulse per gesture.
- The arming/disarming control FSM of the anti-theft system uses these pulses.
- Runs in the same 100 MHz clock domain as debounce, so no synchronizer is needed on clean_in.

Parameters:
LONG_CYCLES, 100_000_000, hold duration in clocks that qualifies a long press (1 s at 100 MHz); must be >= 2
GAP_CYCLES, 30_000_000, maximum released interval in clocks between two taps of a double press (300 ms); must be >= 2
CNT_W, $clog2(max(LONG_CYCLES,GAP_CYCLES))+1, internal counter width (derived, do not override)

Ports:
clock_in  input  1  system clock, rising-edge
reset_in  input  1  asynchronous, active-low reset
clean_in  input  1  debounced button level from debounce clean_out, 1 = pressed
short_press_out  output  1  one-cycle pulse: single tap, no follow-up within the gap
double_press_out  output  1  one-cycle pulse: two taps within the gap
long_press_out  output  1  one-cycle pulse: held for LONG_CYCLES
busy_out  output  1  high while a gesture is in progress (state not INIT/IDLE)

Behaviour:
- Reset (reset_in low, asynchronous):
  - state=INIT, counter=0, all outputs 0, held while reset_in low.
  - Release is sampled on the first clock_in edge with reset_in high.
- All outputs are registered. Pulses are exactly one cycle wide. At most one pulse per gesture, and pulses are mutually exclusive.
- The FSM samples clean_in at each rising edge. The counter clears on every state entry and increments each edge while the state is held.
- INIT: wait for clean_in=0, then go to IDLE. A button held through reset never produces an event.
- IDLE: clean_in=1 -> PRESS1 (call this edge T0).
- PRESS1:
  - clean_in=1 and counter==LONG_CYCLES-1 -> LONG_HELD, long_press_out=1. long_press_out is high in the cycle after edge T0+LONG_CYCLES.
  - clean_in=0 earlier -> WAIT_GAP.
- WAIT_GAP:
  - clean_in=1 -> PRESS2.
  - Otherwise, counter==GAP_CYCLES-1 -> IDLE, short_press_out=1. short_press_out is high in the cycle after the GAP_CYCLES-th edge following the release edge.
  - Simultaneous event: clean_in=1 on the timeout edge takes PRESS2. The re-press wins and no short pulse is emitted.
- PRESS2:
  - clean_in=0 -> IDLE, double_press_out=1 in the next cycle.
  - clean_in=1 and counter==LONG_CYCLES-1 -> LONG_HELD, long_press_out=1. The first tap is discarded and no double pulse is emitted.
- LONG_HELD: no outputs. clean_in=0 -> IDLE. Holding indefinitely produces no repeat pulses.
- busy_out=1 in PRESS1, WAIT_GAP, PRESS2 and LONG_HELD; registered alongside the state.
- Counter saturation: the counter never exceeds max(LONG_CYCLES,GAP_CYCLES)-1; the terminal compares occur before wrap.
- Reset mid-gesture:
  - Immediately clears state, counter and outputs.
  - A pulse in flight is dropped.
  - The gesture restarts from INIT, so the button must be seen released before a new gesture is recognized.
- Undefined state encodings recover to INIT.

Test Plan:
All scenarios use LONG_CYCLES=20, GAP_CYCLES=10, clean_in driven synchronously.
1. Reset with clean_in=1 held 50 cycles through and after reset release, then clean_in=0 for 30 cycles -> no pulses, busy_out=0 throughout.
2. From IDLE: press 5 cycles, release -> short_press_out high for exactly one cycle, after the 10th edge following the release edge; double and long pulses stay 0.
3. Press 5, release 4, press 5, release -> double_press_out one cycle after the second release edge; short_press_out never asserts.
4. Press 5, release, re-assert clean_in exactly on the 10th edge after release, hold 3, release -> double_press_out only; no short pulse (simultaneous-event rule).
5. Hold clean_in=1 for 40 cycles from T0 -> long_press_out pulses once, in the cycle after edge T0+20; no further pulses on release. Repeat with a first tap then a second press held 25 cycles -> long_press_out only.
6. Press 5, release 3, press again, then assert reset_in=0 for 2 cycles mid-PRESS2 with clean_in still high -> outputs 0 asynchronously, busy_out=0; after release no pulse until clean_in goes 0, then a fresh 5-cycle tap yields a normal short pulse.

Source files
------------

// File: rtl/press_classifier.sv
// Classifies debounced button gestures into short, double and long press pulses.
// Latency: each pulse is registered and appears in the cycle after the deciding clock edge.
// Backpressure: none; this is a free-running classifier and each pulse lasts one cycle.
module press_classifier #(
    parameter int LONG_CYCLES = 100_000_000,
    parameter int GAP_CYCLES  = 30_000_000
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic clean_in,
    output logic short_press_out,
    output logic double_press_out,
    output logic long_press_out,
    output logic busy_out
);

    localparam int MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_PRESS1    = 3'd2,
        ST_WAIT_GAP  = 3'd3,
        ST_PRESS2    = 3'd4,
        ST_LONG_HELD = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             busy_q, busy_d;

    // State, counter and registered outputs; reset drops any pulse in flight.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state decision; release is tested before the long-hold compare so it wins a tie.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                // A button held through reset must be released before anything counts.
                if (!clean_in) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (clean_in) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (!clean_in)               state_d = ST_WAIT_GAP;
                else if (cnt_q == LONG_LAST) state_d = ST_LONG_HELD;
            end
            ST_WAIT_GAP: begin
                // A re-press on the timeout edge still counts as the second tap.
                if (clean_in)               state_d = ST_PRESS2;
                else if (cnt_q == GAP_LAST) state_d = ST_IDLE;
            end
            ST_PRESS2: begin
                if (!clean_in)               state_d = ST_IDLE;
                else if (cnt_q == LONG_LAST) state_d = ST_LONG_HELD;
            end
            ST_LONG_HELD: begin
                if (!clean_in) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Counter clears on every state change and saturates while a state is held.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Pulses come from the transition taken this edge, so each gesture yields at most one.
    always_comb begin
        short_d  = (state_q == ST_WAIT_GAP) && (state_d == ST_IDLE);
        double_d = (state_q == ST_PRESS2)   && (state_d == ST_IDLE);
        long_d   = (state_q != ST_LONG_HELD) && (state_d == ST_LONG_HELD);
        busy_d   = (state_d != ST_INIT) && (state_d != ST_IDLE);
    end

    assign short_press_out  = short_q;
    assign double_press_out = double_q;
    assign long_press_out   = long_q;
    assign busy_out         = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with LONG_CYCLES=20 and GAP_CYCLES=10.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Every pulse is logged with the number of the edge that produced it.
module tb_press_classifier;

    logic clock_in;
    logic reset_in;
    logic clean_in;
    logic short_press_out;
    logic double_press_out;
    logic long_press_out;
    logic busy_out;

    press_classifier #(
        .LONG_CYCLES(20),
        .GAP_CYCLES (10)
    ) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .clean_in        (clean_in),
        .short_press_out (short_press_out),
        .double_press_out(double_press_out),
        .long_press_out  (long_press_out),
        .busy_out        (busy_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    int n_cmp;
    int n_err;
    int cyc;
    int short_cnt, double_cnt, long_cnt;
    int short_cyc, double_cyc, long_cyc;
    int excl_viol;
    bit busy_seen;

    task automatic clear_mon();
        short_cnt = 0; double_cnt = 0; long_cnt = 0;
        short_cyc = -1; double_cyc = -1; long_cyc = -1;
        excl_viol = 0; busy_seen = 1'b0;
    endtask

    // Advance n rising edges, logging every output seen just after each edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_in);
            #1;
            cyc++;
            if (short_press_out === 1'b1)  begin short_cnt++;  short_cyc  = cyc; end
            if (double_press_out === 1'b1) begin double_cnt++; double_cyc = cyc; end
            if (long_press_out === 1'b1)   begin long_cnt++;   long_cyc   = cyc; end
            if (busy_out === 1'b1) busy_seen = 1'b1;
            if ((int'(short_press_out) + int'(double_press_out) + int'(long_press_out)) > 1) excl_viol++;
        end
    endtask

    task automatic test_reset();
        int e_s, e_d, e_l, e_b;
        reset_in = 1'b0;
        clean_in = 1'b1;
        #2;
        e_s = 0; e_d = 0; e_l = 0; e_b = 0;
        n_cmp++; if (short_press_out !== 1'b0)  begin n_err++; $display("FAIL reset_short: got %b want %0d", short_press_out, e_s); end
        n_cmp++; if (double_press_out !== 1'b0) begin n_err++; $display("FAIL reset_double: got %b want %0d", double_press_out, e_d); end
        n_cmp++; if (long_press_out !== 1'b0)   begin n_err++; $display("FAIL reset_long: got %b want %0d", long_press_out, e_l); end
        n_cmp++; if (busy_out !== 1'b0)         begin n_err++; $display("FAIL reset_busy: got %b want %0d", busy_out, e_b); end
        clear_mon();
        tick(3);
        reset_in = 1'b1;
        tick(47);
        clean_in = 1'b0;
        tick(30);
        n_cmp++; if (short_cnt + double_cnt + long_cnt != 0) begin n_err++; $display("FAIL held_thru_reset_pulses: got %0d want 0", short_cnt + double_cnt + long_cnt); end
        n_cmp++; if (busy_seen !== 1'b0) begin n_err++; $display("FAIL held_thru_reset_busy: got %b want 0", busy_seen); end
    endtask

    task automatic test_short();
        int rel;
        clear_mon();
        clean_in = 1'b1;
        tick(5);
        clean_in = 1'b0;
        rel = cyc + 1;
        tick(15);
        n_cmp++; if (short_cnt != 1)        begin n_err++; $display("FAIL short_count: got %0d want 1", short_cnt); end
        n_cmp++; if (short_cyc != rel + 10) begin n_err++; $display("FAIL short_timing: got edge %0d want edge %0d", short_cyc, rel + 10); end
        n_cmp++; if (double_cnt + long_cnt != 0) begin n_err++; $display("FAIL short_others: got %0d want 0", double_cnt + long_cnt); end
        n_cmp++; if (busy_seen !== 1'b1)    begin n_err++; $display("FAIL short_busy_seen: got %b want 1", busy_seen); end
        n_cmp++; if (busy_out !== 1'b0)     begin n_err++; $display("FAIL short_busy_end: got %b want 0", busy_out); end
    endtask

    task automatic test_double();
        int rel2;
        clear_mon();
        clean_in = 1'b1; tick(5);
        clean_in = 1'b0; tick(4);
        clean_in = 1'b1; tick(5);
        clean_in = 1'b0;
        rel2 = cyc + 1;
        tick(15);
        n_cmp++; if (double_cnt != 1)     begin n_err++; $display("FAIL double_count: got %0d want 1", double_cnt); end
        n_cmp++; if (double_cyc != rel2)  begin n_err++; $display("FAIL double_timing: got edge %0d want edge %0d", double_cyc, rel2); end
        n_cmp++; if (short_cnt != 0)      begin n_err++; $display("FAIL double_no_short: got %0d want 0", short_cnt); end
        n_cmp++; if (long_cnt != 0)       begin n_err++; $display("FAIL double_no_long: got %0d want 0", long_cnt); end
    endtask

    // Re-press lands on the same edge at which the gap would time out.
    task automatic test_simultaneous();
        int rel2;
        clear_mon();
        clean_in = 1'b1; tick(5);
        clean_in = 1'b0; tick(10);
        clean_in = 1'b1; tick(3);
        clean_in = 1'b0;
        rel2 = cyc + 1;
        tick(15);
        n_cmp++; if (short_cnt != 0)     begin n_err++; $display("FAIL simul_no_short: got %0d want 0", short_cnt); end
        n_cmp++; if (double_cnt != 1)    begin n_err++; $display("FAIL simul_double_count: got %0d want 1", double_cnt); end
        n_cmp++; if (double_cyc != rel2) begin n_err++; $display("FAIL simul_double_timing: got edge %0d want edge %0d", double_cyc, rel2); end
    endtask

    task automatic test_long();
        int t0;
        clear_mon();
        clean_in = 1'b1;
        t0 = cyc + 1;
        tick(40);
        clean_in = 1'b0;
        tick(20);
        n_cmp++; if (long_cnt != 1)       begin n_err++; $display("FAIL long_count: got %0d want 1", long_cnt); end
        n_cmp++; if (long_cyc != t0 + 20) begin n_err++; $display("FAIL long_timing: got edge %0d want edge %0d", long_cyc, t0 + 20); end
        n_cmp++; if (short_cnt + double_cnt != 0) begin n_err++; $display("FAIL long_others: got %0d want 0", short_cnt + double_cnt); end
        n_cmp++; if (busy_out !== 1'b0)   begin n_err++; $display("FAIL long_busy_end: got %b want 0", busy_out); end
    endtask

    // First tap followed by a second press held past the long threshold.
    task automatic test_long_second();
        int p;
        clear_mon();
        clean_in = 1'b1; tick(5);
        clean_in = 1'b0; tick(3);
        clean_in = 1'b1;
        p = cyc + 1;
        tick(25);
        clean_in = 1'b0;
        tick(20);
        n_cmp++; if (long_cnt != 1)      begin n_err++; $display("FAIL long2_count: got %0d want 1", long_cnt); end
        n_cmp++; if (long_cyc != p + 20) begin n_err++; $display("FAIL long2_timing: got edge %0d want edge %0d", long_cyc, p + 20); end
        n_cmp++; if (double_cnt != 0)    begin n_err++; $display("FAIL long2_no_double: got %0d want 0", double_cnt); end
        n_cmp++; if (short_cnt != 0)     begin n_err++; $display("FAIL long2_no_short: got %0d want 0", short_cnt); end
    endtask

    // 20 pressed samples release on the threshold edge (short); 21 reach it (long).
    task automatic test_long_boundary();
        int rel, t0;
        clear_mon();
        clean_in = 1'b1; tick(20);
        clean_in = 1'b0;
        rel = cyc + 1;
        tick(15);
        n_cmp++; if (long_cnt != 0)         begin n_err++; $display("FAIL bound20_no_long: got %0d want 0", long_cnt); end
        n_cmp++; if (short_cyc != rel + 10) begin n_err++; $display("FAIL bound20_short: got edge %0d want edge %0d", short_cyc, rel + 10); end
        clear_mon();
        clean_in = 1'b1;
        t0 = cyc + 1;
        tick(21);
        clean_in = 1'b0;
        tick(15);
        n_cmp++; if (long_cyc != t0 + 20)   begin n_err++; $display("FAIL bound21_long: got edge %0d want edge %0d", long_cyc, t0 + 20); end
        n_cmp++; if (short_cnt != 0)        begin n_err++; $display("FAIL bound21_no_short: got %0d want 0", short_cnt); end
    endtask

    task automatic test_reset_mid();
        int rel;
        clear_mon();
        clean_in = 1'b1; tick(5);
        clean_in = 1'b0; tick(3);
        clean_in = 1'b1; tick(4);
        n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", busy_out); end
        #2;
        reset_in = 1'b0;
        #1;
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL mid_async_busy: got %b want 0", busy_out); end
        n_cmp++; if ({short_press_out, double_press_out, long_press_out} !== 3'b000) begin n_err++; $display("FAIL mid_async_pulses: got %b want 000", {short_press_out, double_press_out, long_press_out}); end
        tick(2);
        reset_in = 1'b1;
        clear_mon();
        tick(30);
        n_cmp++; if (short_cnt + double_cnt + long_cnt != 0) begin n_err++; $display("FAIL mid_after_reset_pulses: got %0d want 0", short_cnt + double_cnt + long_cnt); end
        n_cmp++; if (busy_seen !== 1'b0) begin n_err++; $display("FAIL mid_after_reset_busy: got %b want 0", busy_seen); end
        clean_in = 1'b0; tick(5);
        clear_mon();
        clean_in = 1'b1; tick(5);
        clean_in = 1'b0;
        rel = cyc + 1;
        tick(15);
        n_cmp++; if (short_cnt != 1)        begin n_err++; $display("FAIL mid_fresh_short_count: got %0d want 1", short_cnt); end
        n_cmp++; if (short_cyc != rel + 10) begin n_err++; $display("FAIL mid_fresh_short_timing: got edge %0d want edge %0d", short_cyc, rel + 10); end
        n_cmp++; if (double_cnt + long_cnt != 0) begin n_err++; $display("FAIL mid_fresh_others: got %0d want 0", double_cnt + long_cnt); end
    endtask

    int total_excl;

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        total_excl = 0;
        reset_in = 1'b0;
        clean_in = 1'b1;
        clear_mon();
        test_reset();          total_excl += excl_viol;
        test_short();          total_excl += excl_viol;
        test_double();         total_excl += excl_viol;
        test_simultaneous();   total_excl += excl_viol;
        test_long();           total_excl += excl_viol;
        test_long_second();    total_excl += excl_viol;
        test_long_boundary();  total_excl += excl_viol;
        test_reset_mid();      total_excl += excl_viol;
        n_cmp++; if (total_excl != 0) begin n_err++; $display("FAIL exclusive_pulses: got %0d overlapping cycles want 0", total_excl); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
